// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and data sides
module mem_arbiter #(
  parameter int LATENCY   = 1,
  parameter int MAX_D_RUN = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [15:0] IAddr,
  output logic [31:0] IData,
  output logic        IValid,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [15:0] DAddr,
  input  logic [31:0] DWData,
  input  logic [1:0]  DLane,
  output logic [31:0] DRData,
  output logic        DValid,
  output logic [15:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  MemLane,
  input  logic [31:0] MemRData,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateType;

  localparam logic [3:0] LatCount = 4'(LATENCY);
  localparam logic [3:0] RunMax   = 4'(MAX_D_RUN);

  stateType   state;
  logic [3:0] waitCount;
  logic [3:0] dRun;
  logic       grantIsD;
  logic       accWrite;
  logic       grantD;
  logic       grantI;

  // D side wins unless it has already taken MAX_D_RUN grants while fetch waited
  always_comb begin
    grantD = DReq && !(IReq && (dRun == RunMax));
    grantI = !grantD && IReq;
  end

  // access sequencer: the Mem* strobes and address/data are registered so that
  // they are live only during the single ISSUE cycle and zero otherwise
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      waitCount <= '0;
      dRun      <= '0;
      grantIsD  <= 1'b0;
      accWrite  <= 1'b0;
      IData     <= '0;
      IValid    <= 1'b0;
      DRData    <= '0;
      DValid    <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      MemLane   <= '0;
      Busy      <= 1'b0;
    end else begin
      IValid   <= 1'b0;
      DValid   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      MemLane  <= '0;
      case (state)
        IDLE: begin
          if (grantD || grantI) begin
            state    <= ISSUE;
            Busy     <= 1'b1;
            grantIsD <= grantD;
            accWrite <= grantD && DWrite;
            MemAddr  <= grantD ? DAddr : IAddr;
            MemRead  <= !(grantD && DWrite);
            MemWrite <= grantD && DWrite;
            MemWData <= (grantD && DWrite) ? DWData : '0;
            MemLane  <= (grantD && DWrite) ? DLane : 2'b00;
            if (grantD) begin
              if (IReq) begin
                dRun <= (dRun == RunMax) ? RunMax : dRun + 4'd1;
              end else begin
                dRun <= '0;
              end
            end else begin
              dRun <= '0;
            end
          end
        end
        ISSUE: begin
          if (accWrite) begin
            state  <= DONE;
            DValid <= 1'b1;
          end else begin
            waitCount <= LatCount;
            state     <= WAIT;
          end
        end
        WAIT: begin
          waitCount <= waitCount - 4'd1;
          // count reaches 1 in cycle ISSUE+LATENCY, when MemRData is valid
          if (waitCount == 4'd1) begin
            state <= DONE;
            if (grantIsD) begin
              DRData <= MemRData;
              DValid <= 1'b1;
            end else begin
              IData  <= MemRData;
              IValid <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // the memory never sees a read and a write strobe in the same cycle
  assert property (@(posedge Clock) disable iff (Reset) !(MemRead && MemWrite));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed checks for mem_arbiter
module tb_mem_arbiter;

  localparam int MaxRun = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        IReq;
  logic [15:0] IAddr;
  logic        DReq;
  logic        DWrite;
  logic [15:0] DAddr;
  logic [31:0] DWData;
  logic [1:0]  DLane;
  logic [31:0] MemRData;

  logic [31:0] iData    [3];
  logic        iValid   [3];
  logic [31:0] dRData   [3];
  logic        dValid   [3];
  logic [15:0] memAddr  [3];
  logic [31:0] memWData [3];
  logic        memRead  [3];
  logic        memWrite [3];
  logic [1:0]  memLane  [3];
  logic        busy     [3];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sel = 0;
  logic [31:0] rdHist [int];

  always #5 Clock = ~Clock;

  mem_arbiter #(.LATENCY(1), .MAX_D_RUN(MaxRun)) dutL1 (
    .Clock(Clock), .Reset(Reset), .IReq(IReq), .IAddr(IAddr), .IData(iData[0]), .IValid(iValid[0]),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData), .DLane(DLane),
    .DRData(dRData[0]), .DValid(dValid[0]), .MemAddr(memAddr[0]), .MemWData(memWData[0]),
    .MemRead(memRead[0]), .MemWrite(memWrite[0]), .MemLane(memLane[0]), .MemRData(MemRData),
    .Busy(busy[0]));

  mem_arbiter #(.LATENCY(3), .MAX_D_RUN(MaxRun)) dutL3 (
    .Clock(Clock), .Reset(Reset), .IReq(IReq), .IAddr(IAddr), .IData(iData[1]), .IValid(iValid[1]),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData), .DLane(DLane),
    .DRData(dRData[1]), .DValid(dValid[1]), .MemAddr(memAddr[1]), .MemWData(memWData[1]),
    .MemRead(memRead[1]), .MemWrite(memWrite[1]), .MemLane(memLane[1]), .MemRData(MemRData),
    .Busy(busy[1]));

  mem_arbiter #(.LATENCY(4), .MAX_D_RUN(MaxRun)) dutL4 (
    .Clock(Clock), .Reset(Reset), .IReq(IReq), .IAddr(IAddr), .IData(iData[2]), .IValid(iValid[2]),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData), .DLane(DLane),
    .DRData(dRData[2]), .DValid(dValid[2]), .MemAddr(memAddr[2]), .MemWData(memWData[2]),
    .MemRead(memRead[2]), .MemWrite(memWrite[2]), .MemLane(memLane[2]), .MemRData(MemRData),
    .Busy(busy[2]));

  function automatic int latOf(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
  endfunction

  // advance one cycle; a fresh random read-data word is presented every cycle
  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
    MemRData = $urandom();
    rdHist[cyc] = MemRData;
  endtask

  task automatic doReset();
    IReq = 0; DReq = 0; DWrite = 0; IAddr = '0; DAddr = '0; DWData = '0; DLane = '0;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; IReq = 1; DReq = 1; DWrite = 1; IAddr = 16'h1234; DAddr = 16'h5678;
    DWData = 32'hCAFEF00D; DLane = 2'b11; MemRData = '0;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      tests++;
      if ({iData[s], dRData[s], iValid[s], dValid[s], memAddr[s], memWData[s], memRead[s],
           memWrite[s], memLane[s], busy[s]} !== 119'd0) begin
        fails++;
        $display("FAIL reset_outputs inst%0d: got busy=%b ird=%b mwr=%b addr=%h, want all zero",
                 s, busy[s], memRead[s], memWrite[s], memAddr[s]);
      end
    end
    IReq = 0; DReq = 0; DWrite = 0;
    Reset = 1'b0;
  endtask

  task automatic test_fetch_read();
    sel = 0;
    doReset();
    IReq = 1; IAddr = 16'h0010;
    tick();
    tests++;
    if (memRead[0] !== 1'b1 || memAddr[0] !== 16'h0010 || memWrite[0] !== 1'b0) begin
      fails++;
      $display("FAIL fetch_issue: got MemRead=%b MemAddr=%h MemWrite=%b, want 1 0010 0",
               memRead[0], memAddr[0], memWrite[0]);
    end
    tick();
    MemRData = 32'hDEADBEEF;
    rdHist[cyc] = MemRData;
    tests++;
    if (iValid[0] !== 1'b0) begin
      fails++;
      $display("FAIL fetch_early_valid: got IValid=%b, want 0", iValid[0]);
    end
    tick();
    tests++;
    if (iValid[0] !== 1'b1 || iData[0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL fetch_complete: got IValid=%b IData=%h, want 1 deadbeef", iValid[0], iData[0]);
    end
    IReq = 0;
    tick();
    tests++;
    if (iValid[0] !== 1'b0 || iData[0] !== 32'hDEADBEEF || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL fetch_hold: got IValid=%b IData=%h Busy=%b, want 0 deadbeef 0",
               iValid[0], iData[0], busy[0]);
    end
  endtask

  task automatic test_write();
    sel = 0;
    doReset();
    DReq = 1; DWrite = 1; DAddr = 16'h0100; DWData = 32'h12345678; DLane = 2'b10;
    tick();
    tests++;
    if (memWrite[0] !== 1'b1 || memRead[0] !== 1'b0 || memLane[0] !== 2'b10 ||
        memWData[0] !== 32'h12345678 || memAddr[0] !== 16'h0100 || dValid[0] !== 1'b0) begin
      fails++;
      $display("FAIL write_issue: got wr=%b rd=%b lane=%b wdata=%h addr=%h dv=%b, want 1 0 10 12345678 0100 0",
               memWrite[0], memRead[0], memLane[0], memWData[0], memAddr[0], dValid[0]);
    end
    tick();
    tests++;
    if (dValid[0] !== 1'b1 || memWrite[0] !== 1'b0 || memLane[0] !== 2'b00) begin
      fails++;
      $display("FAIL write_done: got DValid=%b MemWrite=%b MemLane=%b, want 1 0 00",
               dValid[0], memWrite[0], memLane[0]);
    end
    DReq = 0;
    tick();
    tests++;
    if (dValid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL write_after: got DValid=%b Busy=%b, want 0 0", dValid[0], busy[0]);
    end
  endtask

  task automatic test_simultaneous();
    int c0;
    logic [3:0] want;
    sel = 0;
    doReset();
    c0 = cyc;
    IReq = 1; IAddr = 16'h0300;
    DReq = 1; DWrite = 0; DAddr = 16'h0200;
    for (int k = 1; k <= 8; k++) begin
      tick();
      want = {((k >= 1 && k <= 3) || (k >= 5 && k <= 7)), (k == 1 || k == 5), (k == 7), (k == 3)};
      tests++;
      if ({busy[0], memRead[0], iValid[0], dValid[0]} !== want) begin
        fails++;
        $display("FAIL simul_ctrl cycle %0d: got busy/rd/iv/dv=%b, want %b", k,
                 {busy[0], memRead[0], iValid[0], dValid[0]}, want);
      end
      if (k == 1 || k == 5) begin
        tests++;
        if (memAddr[0] !== ((k == 1) ? 16'h0200 : 16'h0300)) begin
          fails++;
          $display("FAIL simul_addr cycle %0d: got %h", k, memAddr[0]);
        end
      end
      if (k == 3) begin
        tests++;
        if (dRData[0] !== rdHist[c0 + 2]) begin
          fails++;
          $display("FAIL simul_ddata: got %h, want %h", dRData[0], rdHist[c0 + 2]);
        end
        DReq = 0;
      end
      if (k == 7) begin
        tests++;
        if (iData[0] !== rdHist[c0 + 6]) begin
          fails++;
          $display("FAIL simul_idata: got %h, want %h", iData[0], rdHist[c0 + 6]);
        end
        IReq = 0;
      end
    end
  endtask

  task automatic test_starvation();
    byte got[$];
    byte want[$];
    int dDone;
    int run;
    int dLeft;
    bit iPend;
    sel = 0;
    doReset();
    IReq = 1; IAddr = 16'h0040;
    DReq = 1; DWrite = 1; DAddr = 16'h0080; DWData = 32'h0BADCAFE; DLane = 2'b11;
    dDone = 0;
    for (int b = 0; b < 200 && got.size() < 7; b++) begin
      tick();
      if (memWrite[0] === 1'b1) got.push_back("D");
      if (memRead[0] === 1'b1) got.push_back("I");
      if (dValid[0] === 1'b1) begin
        dDone++;
        if (dDone == 6) DReq = 0;
      end
      if (iValid[0] === 1'b1) IReq = 0;
    end
    IReq = 0; DReq = 0;
    run = 0; iPend = 1; dLeft = 6;
    while (dLeft > 0 || iPend) begin
      if (dLeft > 0 && !(iPend && run == MaxRun)) begin
        want.push_back("D");
        dLeft--;
        run = iPend ? ((run < MaxRun) ? run + 1 : MaxRun) : 0;
      end else begin
        want.push_back("I");
        iPend = 0;
        run = 0;
      end
    end
    tests++;
    if (got.size() != want.size()) begin
      fails++;
      $display("FAIL starve_count: got %0d grants, want %0d", got.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] != want[i]) begin
        fails++;
        $display("FAIL starve_order grant %0d: got %c, want %c", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_wait();
    int c0;
    sel = 1;
    doReset();
    IReq = 1; IAddr = 16'h0044;
    tick();
    tick();
    tests++;
    if (busy[1] !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy: got Busy=%b, want 1", busy[1]);
    end
    Reset = 1'b1; IReq = 0;
    tick();
    tests++;
    if ({iData[1], dRData[1], iValid[1], dValid[1], memAddr[1], memWData[1], memRead[1],
         memWrite[1], memLane[1], busy[1]} !== 119'd0) begin
      fails++;
      $display("FAIL abort_zero: got busy=%b iv=%b rd=%b, want all zero", busy[1], iValid[1], memRead[1]);
    end
    Reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (iValid[1] !== 1'b0 || busy[1] !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_valid +%0d: got IValid=%b Busy=%b, want 0 0", k, iValid[1], busy[1]);
      end
    end
    c0 = cyc;
    IReq = 1; IAddr = 16'h0055;
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests++;
      if ({memRead[1], iValid[1]} !== {(k == 1), (k == 5)}) begin
        fails++;
        $display("FAIL after_abort cycle %0d: got rd/iv=%b%b", k, memRead[1], iValid[1]);
      end
      if (k == 5) begin
        tests++;
        if (iData[1] !== rdHist[c0 + 4]) begin
          fails++;
          $display("FAIL after_abort_data: got %h, want %h", iData[1], rdHist[c0 + 4]);
        end
        IReq = 0;
      end
    end
  endtask

  task automatic test_latency4();
    int c0;
    logic v;
    logic [31:0] d;
    sel = 2;
    for (int side = 0; side < 2; side++) begin
      doReset();
      c0 = cyc;
      if (side == 0) begin
        IReq = 1; IAddr = 16'h0066;
      end else begin
        DReq = 1; DWrite = 0; DAddr = 16'h0077;
      end
      for (int k = 1; k <= 6; k++) begin
        tick();
        v = (side == 0) ? iValid[2] : dValid[2];
        d = (side == 0) ? iData[2] : dRData[2];
        tests++;
        if (v !== (k == 6)) begin
          fails++;
          $display("FAIL lat4_valid side%0d cycle %0d: got %b", side, k, v);
        end
        if (k == 6) begin
          tests++;
          if (d !== rdHist[c0 + 5]) begin
            fails++;
            $display("FAIL lat4_data side%0d: got %h, want %h", side, d, rdHist[c0 + 5]);
          end
          IReq = 0; DReq = 0;
        end
      end
    end
  endtask

  // transaction-level model: an access granted at cycle t strobes at t+1 and
  // completes at t+2 (write) or t+LATENCY+2 (read); the next sample is after that
  task automatic test_random(input int s, input int n);
    int lat, freeAt, sCyc, cCyc, run;
    bit expI, expW;
    logic [15:0] expAddr;
    logic [31:0] expWData;
    logic [1:0]  expLane;
    logic [4:0]  want;
    logic [31:0] gotData;
    sel = s;
    lat = latOf(s);
    doReset();
    freeAt = cyc; sCyc = -100; cCyc = -100; run = 0;
    expI = 0; expW = 0; expAddr = '0; expWData = '0; expLane = '0;
    repeat (n) begin
      want = {(cyc >= sCyc && cyc <= cCyc), (cyc == sCyc && !expW), (cyc == sCyc && expW),
              (cyc == cCyc && expI), (cyc == cCyc && !expI)};
      tests++;
      if ({busy[s], memRead[s], memWrite[s], iValid[s], dValid[s]} !== want) begin
        fails++;
        $display("FAIL rand_ctrl inst%0d cyc %0d: got busy/rd/wr/iv/dv=%b, want %b", s, cyc,
                 {busy[s], memRead[s], memWrite[s], iValid[s], dValid[s]}, want);
      end
      if (cyc == sCyc) begin
        tests++;
        if (memAddr[s] !== expAddr || memWData[s] !== (expW ? expWData : 32'd0) ||
            memLane[s] !== (expW ? expLane : 2'b00)) begin
          fails++;
          $display("FAIL rand_issue inst%0d cyc %0d: got addr=%h wd=%h lane=%b, want %h %h %b", s, cyc,
                   memAddr[s], memWData[s], memLane[s], expAddr, expW ? expWData : 32'd0,
                   expW ? expLane : 2'b00);
        end
      end
      if (cyc == cCyc && !expW) begin
        gotData = expI ? iData[s] : dRData[s];
        tests++;
        if (gotData !== rdHist[sCyc + lat]) begin
          fails++;
          $display("FAIL rand_rdata inst%0d cyc %0d: got %h, want %h", s, cyc, gotData, rdHist[sCyc + lat]);
        end
      end
      if (cyc == cCyc) begin
        if (expI) IReq = 0;
        else DReq = 0;
      end
      if (!IReq && $urandom_range(0, 2) == 0) begin
        IReq = 1; IAddr = 16'($urandom());
      end
      if (!DReq && $urandom_range(0, 1) == 0) begin
        DReq = 1; DWrite = 1'($urandom_range(0, 1)); DAddr = 16'($urandom());
        DWData = $urandom(); DLane = 2'($urandom_range(0, 3));
      end
      if (cyc >= freeAt && (IReq || DReq)) begin
        if (DReq && !(IReq && run == MaxRun)) begin
          expI = 0; expW = DWrite; expAddr = DAddr; expWData = DWData; expLane = DLane;
          run = IReq ? ((run < MaxRun) ? run + 1 : MaxRun) : 0;
        end else begin
          expI = 1; expW = 0; expAddr = IAddr;
          run = 0;
        end
        sCyc = cyc + 1;
        cCyc = expW ? cyc + 2 : cyc + lat + 2;
        freeAt = cCyc + 1;
      end
      tick();
    end
    IReq = 0; DReq = 0;
  endtask

  initial begin
    MemRData = '0;
    test_reset();
    test_fetch_read();
    test_write();
    test_simultaneous();
    test_starvation();
    test_reset_wait();
    test_latency4();
    test_random(0, 1500);
    test_random(2, 1500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
